ram_cpu_dp: RTL and testbench

Parametrised simple dual-port data RAM for the processor datapath: one write port with byte enables, one registered read port with valid flag, and a built-in clear sequencer that zeroes every word after reset or on request. It replaces the fixed 32×1024 CPU RAM with a configurable-width/depth memory. The CPU load/store unit sits on the write and read ports and must hold off while `busy` is high.

---
 rtl/ram_cpu_pkg.sv | 18 +
 rtl/ram_cpu_clear_seq.sv | 76 +++++++
 rtl/ram_cpu_dp.sv | 131 +++++++++++++
 tb/tb_ram_cpu_dp.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_cpu_pkg.sv
// ram_cpu_pkg
//   Shared definitions for the ram_cpu_dp data RAM and its clear sequencer:
//   byte width, clear FSM state encoding and a byte-lane count helper.
package ram_cpu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Number of byte lanes in a word of data_w bits.
  function automatic int num_bytes(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_cpu_clear_seq.sv
// ram_cpu_clear_seq
//   Clear sequencer for ram_cpu_dp. Sweeps every word address from 0 to
//   DEPTH-1 and asserts a write-zero enable for each, after reset release or
//   on a clr_req pulse while idle. clr_req during a sweep is ignored.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      synchronous active-low reset (forces CLEAR, cnt = 0)
//   clr_req_i   one-cycle clear request
//   busy_o      sweep in progress (state == CLEAR)
//   clr_addr_o  word address being cleared
//   clr_we_o    write-zero enable for clr_addr_o
module ram_cpu_clear_seq
  import ram_cpu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              clr_we_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // Set by reset and dropped on the first edge after release. That first
  // edge only arms the sweep, just like the edge that samples clr_req, so
  // both start paths keep busy high for exactly DEPTH edges afterwards.
  logic              arm_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      arm_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arm_q   <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (!arm_q) begin
          clr_we_o = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/ram_cpu_dp.sv
// ram_cpu_dp
//   Parametrised simple dual-port CPU data RAM: one byte-enabled write port,
//   one registered read port with valid flag, and a clear sequencer that
//   zeroes every word after reset or on clr_req. User accesses are ignored
//   while busy. Same-address read during write returns the merged new word.
//
// Ports
//   clock       clock, rising edge
//   aclr_n      synchronous active-low reset
//   clr_req     one-cycle full-clear request
//   busy        clear in progress
//   wren, wraddress, data, byteena   write port (byteena bit i -> data[8i+7:8i])
//   rden, rdaddress                  read port
//   q, q_valid                       read data and its valid flag
//
// Build option
//   RAM_CPU_OUTREG_EN  adds an output pipeline register (2-cycle read latency)
module ram_cpu_dp
  import ram_cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  wren,
  input  logic [ADDR_W-1:0]     wraddress,
  input  logic [DATA_W-1:0]     data,
  input  logic [DATA_W/8-1:0]   byteena,
  input  logic                  rden,
  input  logic [ADDR_W-1:0]     rdaddress,
  output logic [DATA_W-1:0]     q,
  output logic                  q_valid
);

  localparam int               NB      = num_bytes(DATA_W);
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok, rd_ok, rd_in_range, fwd_hit;
  logic [DATA_W-1:0] rd_old, rd_word;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;

  ram_cpu_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk_i      (clock),
    .rst_ni     (aclr_n),
    .clr_req_i  (clr_req),
    .busy_o     (busy),
    .clr_addr_o (clr_addr),
    .clr_we_o   (clr_we)
  );

  assign wr_ok       = wren && !busy && ({1'b0, wraddress} < DEPTH_L);
  assign rd_ok       = rden && !busy;
  assign rd_in_range = ({1'b0, rdaddress} < DEPTH_L);
  // wr_ok already implies an in-range address, so a hit is always in range.
  assign fwd_hit     = wr_ok && (wraddress == rdaddress);

  // Clear writes and user writes never overlap (users are locked out while
  // busy); the clear still takes priority so the mux is explicit.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (byteena[b]) begin
          mem[wraddress][b*BYTE_W +: BYTE_W] <= data[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rd_old = rd_in_range ? mem[rdaddress] : '0;

  // Per-lane forwarding: enabled lanes of a same-edge write replace the old
  // memory bytes, disabled lanes keep them.
  for (genvar gi = 0; gi < NB; gi++) begin : g_fwd
    assign rd_word[gi*BYTE_W +: BYTE_W] = (fwd_hit && byteena[gi])
                                        ? data[gi*BYTE_W +: BYTE_W]
                                        : rd_old[gi*BYTE_W +: BYTE_W];
  end

  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_ok;
      if (rd_ok) begin
        rd_data_q <= rd_word;
      end
    end
  end

  // A read accepted on the same edge that starts a clear would otherwise
  // present a valid result while busy; masking with busy keeps q_valid low
  // for the whole sweep.
`ifdef RAM_CPU_OUTREG_EN
  logic [DATA_W-1:0] out_data_q;
  logic              out_vld_q;

  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      out_vld_q <= rd_vld_q && !busy;
      if (rd_vld_q && !busy) begin
        out_data_q <= rd_data_q;
      end
    end
  end

  assign q       = out_data_q;
  assign q_valid = out_vld_q && !busy;
`else
  assign q       = rd_data_q;
  assign q_valid = rd_vld_q && !busy;
`endif

endmodule

// File: tb/tb_ram_cpu_dp.sv
module tb_ram_cpu_dp;

  localparam int DW = 32;
  localparam int AW = 10;
`ifdef RAM_CPU_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clock = 1'b0;
  logic          aclr_n = 1'b0;
  logic          clr_req = 1'b0;
  logic          wren = 1'b0;
  logic [AW-1:0] wraddress = '0;
  logic [DW-1:0] data = '0;
  logic [3:0]    byteena = '0;
  logic          rden = 1'b0;
  logic [AW-1:0] rdaddress = '0;

  logic          busy_a, qv_a, busy_b, qv_b;
  logic [DW-1:0] q_a, q_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Default geometry: 1024 words.
  ram_cpu_dp u_dut_a (
    .clock(clock), .aclr_n(aclr_n), .clr_req(clr_req), .busy(busy_a),
    .wren(wren), .wraddress(wraddress), .data(data), .byteena(byteena),
    .rden(rden), .rdaddress(rdaddress), .q(q_a), .q_valid(qv_a)
  );

  // Non-power-of-two depth sharing the same stimulus.
  ram_cpu_dp #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000)) u_dut_b (
    .clock(clock), .aclr_n(aclr_n), .clr_req(clr_req), .busy(busy_b),
    .wren(wren), .wraddress(wraddress), .data(data), .byteena(byteena),
    .rden(rden), .rdaddress(rdaddress), .q(q_b), .q_valid(qv_b)
  );

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    @(negedge clock);
    wren = 1'b1; wraddress = a; data = d; byteena = be;
    @(negedge clock);
    wren = 1'b0;
    $display("wr   addr=%03h data=%08h be=%b", a, d, be);
  endtask

  // Returns at the negedge where the read result is expected.
  task automatic rd(input logic [AW-1:0] a);
    @(negedge clock);
    rden = 1'b1; rdaddress = a;
    @(negedge clock);
    rden = 1'b0;
    if (LAT == 2) @(negedge clock);
    $display("rd   addr=%03h q_a=%08h v_a=%b q_b=%08h v_b=%b", a, q_a, qv_a, q_b, qv_b);
  endtask

  task automatic wr_rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    @(negedge clock);
    wren = 1'b1; wraddress = a; data = d; byteena = be;
    rden = 1'b1; rdaddress = a;
    @(negedge clock);
    wren = 1'b0; rden = 1'b0;
    if (LAT == 2) @(negedge clock);
    $display("wrrd addr=%03h data=%08h be=%b q_a=%08h q_b=%08h", a, d, be, q_a, q_b);
  endtask

  // Counts busy cycles of each DUT until both are idle (bounded).
  task automatic count_busy(output int ca, output int cb);
    ca = 0; cb = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (!busy_a && !busy_b) break;
    end
    $display("busy cycles a=%0d b=%0d", ca, cb);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int ca, cb;
    aclr_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got a=%b b=%b expected 1", busy_a, busy_b); end
    n_checks++; if (q_a !== 32'h0 || qv_a !== 1'b0) begin n_fail++; $display("FAIL reset_q: got q=%08h v=%b expected 00000000/0", q_a, qv_a); end
    aclr_n = 1'b1;
    count_busy(ca, cb);
    n_checks++; if (ca !== 1024) begin n_fail++; $display("FAIL reset_sweep_a: got %0d cycles expected 1024", ca); end
    n_checks++; if (cb !== 1000) begin n_fail++; $display("FAIL reset_sweep_b: got %0d cycles expected 1000", cb); end
    rd(10'h3FF);
    n_checks++; if (q_a !== 32'h0 || qv_a !== 1'b1) begin n_fail++; $display("FAIL rd_3ff_a: got q=%08h v=%b expected 00000000/1", q_a, qv_a); end
    n_checks++; if (q_b !== 32'h0 || qv_b !== 1'b1) begin n_fail++; $display("FAIL rd_3ff_b: got q=%08h v=%b expected 00000000/1", q_b, qv_b); end
  endtask

  task automatic test_byte_enable;
    wr(10'h010, 32'hDEADBEEF, 4'b1111);
    wr(10'h010, 32'h00AA0000, 4'b0100);
    rd(10'h010);
    n_checks++; if (q_a !== 32'hDEAABEEF) begin n_fail++; $display("FAIL be_merge_a: got %08h expected DEAABEEF", q_a); end
    n_checks++; if (q_b !== 32'hDEAABEEF) begin n_fail++; $display("FAIL be_merge_b: got %08h expected DEAABEEF", q_b); end
  endtask

  task automatic test_byteena_zero;
    wr(10'h010, 32'h11111111, 4'b0000);
    rd(10'h010);
    n_checks++; if (q_a !== 32'hDEAABEEF) begin n_fail++; $display("FAIL be_zero: got %08h expected DEAABEEF", q_a); end
  endtask

  task automatic test_forwarding;
    wr(10'h020, 32'hFFFFFFFF, 4'b1111);
    wr_rd(10'h020, 32'h12345678, 4'b0011);
    n_checks++; if (q_a !== 32'hFFFF5678 || qv_a !== 1'b1) begin n_fail++; $display("FAIL fwd_a: got %08h v=%b expected FFFF5678/1", q_a, qv_a); end
    n_checks++; if (q_b !== 32'hFFFF5678) begin n_fail++; $display("FAIL fwd_b: got %08h expected FFFF5678", q_b); end
    rd(10'h020);
    n_checks++; if (q_a !== 32'hFFFF5678) begin n_fail++; $display("FAIL fwd_persist: got %08h expected FFFF5678", q_a); end
  endtask

  task automatic test_read_hold;
    rd(10'h010);
    @(negedge clock);
    n_checks++; if (qv_a !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b expected 0", qv_a); end
    n_checks++; if (q_a !== 32'hDEAABEEF) begin n_fail++; $display("FAIL hold_q: got %08h expected DEAABEEF", q_a); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] exp;
    for (int i = 0; i < 4; i++) wr(10'h040 + AW'(i), 32'hA0A00000 + 32'(i), 4'b1111);
    for (int i = 0; i < 4 + LAT; i++) begin
      @(negedge clock);
      if (i >= LAT) begin
        exp = 32'hA0A00000 + 32'(i - LAT);
        $display("b2b  idx=%0d q_a=%08h v_a=%b", i - LAT, q_a, qv_a);
        n_checks++; if (q_a !== exp || qv_a !== 1'b1) begin n_fail++; $display("FAIL b2b_%0d: got %08h v=%b expected %08h/1", i - LAT, q_a, qv_a, exp); end
      end
      rden = (i < 4);
      rdaddress = 10'h040 + AW'(i);
    end
    rden = 1'b0;
  endtask

  task automatic test_out_of_range;
    wr(10'd1010, 32'h00000055, 4'b1111);
    rd(10'd1010);
    n_checks++; if (q_a !== 32'h55) begin n_fail++; $display("FAIL oor_in_a: got %08h expected 00000055", q_a); end
    n_checks++; if (q_b !== 32'h0 || qv_b !== 1'b1) begin n_fail++; $display("FAIL oor_b: got %08h v=%b expected 00000000/1", q_b, qv_b); end
    rd(10'd999);
    n_checks++; if (q_b !== 32'h0 || qv_b !== 1'b1) begin n_fail++; $display("FAIL last_b: got %08h v=%b expected 00000000/1", q_b, qv_b); end
  endtask

  task automatic test_clear_req;
    int ca, cb;
    logic [AW-1:0] addrs [4];
    addrs[0] = 10'd0; addrs[1] = 10'd5; addrs[2] = 10'd999; addrs[3] = 10'd7;
    wr(10'd0,   32'h01010101, 4'b1111);
    wr(10'd5,   32'h05050505, 4'b1111);
    wr(10'd999, 32'h99999999, 4'b1111);
    rd(10'd5);
    n_checks++; if (q_a !== 32'h05050505) begin n_fail++; $display("FAIL pre_clear: got %08h expected 05050505", q_a); end
    @(negedge clock);
    clr_req = 1'b1;
    $display("clr_req pulse");
    ca = 0; cb = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      clr_req = 1'b0; wren = 1'b0; rden = 1'b0;
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (k == 302) begin
        n_checks++; if (qv_a !== 1'b0 || q_a !== 32'h05050505) begin n_fail++; $display("FAIL busy_ignore_rd: got q=%08h v=%b expected 05050505/0", q_a, qv_a); end
      end
      if (k == 300) begin
        clr_req = 1'b1;
        wren = 1'b1; wraddress = 10'd7; data = 32'h77777777; byteena = 4'b1111;
        rden = 1'b1; rdaddress = 10'd5;
        $display("mid-sweep clr_req + write + read");
      end
      if (!busy_a && !busy_b) break;
    end
    $display("busy cycles a=%0d b=%0d", ca, cb);
    n_checks++; if (ca !== 1024) begin n_fail++; $display("FAIL clr_sweep_a: got %0d cycles expected 1024", ca); end
    n_checks++; if (cb !== 1000) begin n_fail++; $display("FAIL clr_sweep_b: got %0d cycles expected 1000", cb); end
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i]);
      n_checks++; if (q_a !== 32'h0 || q_b !== 32'h0) begin n_fail++; $display("FAIL clr_readback_%0d: got a=%08h b=%08h expected 00000000", addrs[i], q_a, q_b); end
    end
  endtask

  task automatic test_reset_mid_clear;
    int ca, cb;
    wr(10'h030, 32'hCAFEF00D, 4'b1111);
    rd(10'h030);
    n_checks++; if (q_a !== 32'hCAFEF00D) begin n_fail++; $display("FAIL pre_rst: got %08h expected CAFEF00D", q_a); end
    @(negedge clock); clr_req = 1'b1;
    @(negedge clock); clr_req = 1'b0;
    repeat (499) @(negedge clock);
    aclr_n = 1'b0;
    $display("aclr_n low mid-sweep");
    repeat (2) @(negedge clock);
    n_checks++; if (busy_a !== 1'b1 || q_a !== 32'h0 || qv_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got busy=%b q=%08h v=%b expected 1/00000000/0", busy_a, q_a, qv_a); end
    aclr_n = 1'b1;
    count_busy(ca, cb);
    n_checks++; if (ca !== 1024) begin n_fail++; $display("FAIL rst_restart_a: got %0d cycles expected 1024", ca); end
    n_checks++; if (cb !== 1000) begin n_fail++; $display("FAIL rst_restart_b: got %0d cycles expected 1000", cb); end
    rd(10'h030);
    n_checks++; if (q_a !== 32'h0 || qv_a !== 1'b1) begin n_fail++; $display("FAIL rst_readback: got %08h v=%b expected 00000000/1", q_a, qv_a); end
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_byteena_zero();
    test_forwarding();
    test_read_hold();
    test_back_to_back();
    test_out_of_range();
    test_clear_req();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
